// File: rtl/relu_stream_arbiter.sv
// relu_stream_arbiter: shares one ReLU between two requesters, granting whole VEC_LEN bursts round-robin.
// Ports: clk, rst (sync, active-high); req/gnt for burst arbitration; s_valid, s_data0, s_data1, s_ready for element input;
// relu_valid, relu_x drive the ReLU, and relu_out, relu_ready return its result; m_* is the tagged result stream; busy means not idle.
module relu_stream_arbiter #(
  parameter int Input_WIDTH = 16,
  parameter int VEC_LEN = 8,
  parameter int IDX_W = $clog2(VEC_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  output logic [1:0]             gnt,
  input  logic [1:0]             s_valid,
  input  logic [Input_WIDTH-1:0] s_data0,
  input  logic [Input_WIDTH-1:0] s_data1,
  output logic [1:0]             s_ready,
  output logic                   relu_valid,
  output logic [Input_WIDTH-1:0] relu_x,
  input  logic [Input_WIDTH-1:0] relu_out,
  input  logic                   relu_ready,
  output logic                   m_valid,
  output logic [Input_WIDTH-1:0] m_data,
  output logic                   m_id,
  output logic [IDX_W-1:0]       m_idx,
  output logic                   m_last,
  output logic                   busy
);
  localparam int CW = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);
  localparam logic [CW-1:0] FULL = CW'(VEC_LEN);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state, state_n;
  logic [1:0] gnt_n;
  logic cur_id, cur_id_n, last_id, last_id_n, win, acc, cap, done;
  logic [CW-1:0] in_cnt, in_cnt_n, out_cnt, out_cnt_n;
  assign s_ready = gnt & {2{state == STREAM}};
  assign busy = state != IDLE;
  assign acc = s_valid[cur_id] & s_ready[cur_id];
  // results count only while a burst is open and never beyond VEC_LEN, so stale ReLU outputs are dropped
  assign cap = relu_ready & busy & (out_cnt != FULL);
  assign done = (out_cnt == FULL) | (cap & (out_cnt == LAST));
  assign win = &req ? ~last_id : req[1];
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    cur_id_n = cur_id;
    last_id_n = last_id;
    in_cnt_n = in_cnt + CW'(acc);
    out_cnt_n = out_cnt + CW'(cap);
    case (state)
      IDLE: begin
        in_cnt_n = '0;
        out_cnt_n = '0;
        if (|req) begin
          state_n = STREAM;
          gnt_n = win ? 2'b10 : 2'b01;
          cur_id_n = win;
        end
      end
      STREAM: state_n = (acc && in_cnt == LAST) ? DRAIN : STREAM;
      DRAIN: if (done) begin
        state_n = IDLE;
        gnt_n = '0;
        last_id_n = cur_id;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      cur_id <= 1'b0;
      last_id <= 1'b1;
      in_cnt <= '0;
      out_cnt <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      cur_id <= cur_id_n;
      last_id <= last_id_n;
      in_cnt <= in_cnt_n;
      out_cnt <= out_cnt_n;
    end
  always_ff @(posedge clk)
    if (rst) begin
      relu_valid <= 1'b0;
      relu_x <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_id <= 1'b0;
      m_idx <= '0;
      m_last <= 1'b0;
    end else begin
      relu_valid <= acc;
      if (acc) relu_x <= cur_id ? s_data1 : s_data0;
      m_valid <= cap;
      m_last <= cap & (out_cnt == LAST);
      if (cap) begin
        m_data <= relu_out;
        m_id <= cur_id;
        m_idx <= out_cnt[IDX_W-1:0];
      end
    end
endmodule

// File: tb/tb_relu_stream_arbiter.sv
// tb_relu_stream_arbiter: directed stimulus with a queue scoreboard checked by an independent result monitor.
module tb_relu_stream_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] s_valid = 2'b00;
  logic [15:0] s_data0 = '0;
  logic [15:0] s_data1 = '0;
  logic [1:0] gnt, s_ready;
  logic relu_valid, relu_ready, m_valid, m_id, m_last, busy;
  logic [15:0] relu_x, relu_out, m_data;
  logic [2:0] m_idx;
  logic rdy_q = 1'b0;
  logic inj = 1'b0;
  logic [15:0] out_q = '0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int w;
  typedef struct {logic id; int idx; logic [15:0] data; logic last; int cyc;} exp_t;
  exp_t exp_q[$];
  logic [15:0] vec_d [4][8];
  logic [15:0] vec_e [4][8];
  relu_stream_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .s_valid(s_valid),
    .s_data0(s_data0), .s_data1(s_data1), .s_ready(s_ready),
    .relu_valid(relu_valid), .relu_x(relu_x), .relu_out(relu_out), .relu_ready(relu_ready),
    .m_valid(m_valid), .m_data(m_data), .m_id(m_id), .m_idx(m_idx), .m_last(m_last), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    rdy_q <= relu_valid;
    out_q <= relu_x[15] ? 16'h0000 : relu_x;
  end
  assign relu_ready = rdy_q | inj;
  assign relu_out = out_q;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  initial begin
    logic [1:0] prev_gnt;
    exp_t e;
    prev_gnt = 2'b00;
    forever begin
      @(negedge clk);
      if (gnt != prev_gnt) begin
        checks++;
        if ((gnt != 2'b00 && prev_gnt != 2'b00) || $countones(gnt) > 1) begin
          errors++;
          $display("FAIL gnt_transition: got %b after %b expected a one-hot grant with an idle gap", gnt, prev_gnt);
        end
        prev_gnt = gnt;
      end
      if (m_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got id=%0d idx=%0d data=%h expected no output", m_id, m_idx, m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_id !== e.id || m_idx !== 3'(e.idx) || m_data !== e.data || m_last !== e.last || cyc != e.cyc) begin
            errors++;
            $display("FAIL result: got id=%0d idx=%0d data=%h last=%0d cyc=%0d expected id=%0d idx=%0d data=%h last=%0d cyc=%0d",
                     m_id, m_idx, m_data, m_last, cyc, e.id, e.idx, e.data, e.last, e.cyc);
          end
        end
        if (m_last === 1'b1) chk("idle_on_last", {busy, gnt}, 0);
      end
    end
  end
  task automatic serve(input int id, input int v, input bit gap, input int n, input int npush, output int wt);
    int t;
    wt = 0;
    t = 0;
    while (gnt != 2'b00 && t < 40) begin @(negedge clk); t++; end
    while (gnt == 2'b00 && wt < 40) begin @(negedge clk); wt++; end
    chk("grant", gnt, 32'(1 << id));
    s_valid[1-id] = 1'b1;
    if (id == 1) s_data0 = 16'h1111; else s_data1 = 16'h1111;
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        s_valid[id] = 1'b0;
        @(negedge clk);
        chk("gap_relu_valid", relu_valid, 0);
        chk("gap_relu_x_hold", relu_x, vec_d[v][i-1]);
      end
      s_valid[id] = 1'b1;
      if (id == 1) s_data1 = vec_d[v][i]; else s_data0 = vec_d[v][i];
      t = 0;
      while (s_ready[id] !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      if (s_ready[id] !== 1'b1) begin
        chk("accept_timeout", s_ready[id], 1);
        break;
      end
      chk("other_s_ready", s_ready[1-id], 0);
      if (i < npush) exp_q.push_back('{1'(id), i, vec_e[v][i], i == 7, cyc + 3});
      @(negedge clk);
      chk("relu_valid", relu_valid, 1);
      chk("relu_x", relu_x, vec_d[v][i]);
    end
    s_valid = 2'b00;
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && t < 60) begin @(negedge clk); t++; end
    chk("idle_timeout", {busy, 31'(exp_q.size())}, 0);
    @(negedge clk);
  endtask
  initial begin
    vec_d = '{'{16'h0003, 16'hFFFB, 16'h0007, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h0002},
              '{16'h0100, 16'h8001, 16'h0001, 16'hFF00, 16'h1234, 16'h0000, 16'h7FFE, 16'hC000},
              '{16'hFFF0, 16'h0010, 16'h0020, 16'h8000, 16'h0030, 16'h7FFF, 16'hFFFF, 16'h0005},
              '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hFFFC, 16'hFFFD, 16'hFFFE, 16'h0008}};
    vec_e = '{'{16'h0003, 16'h0000, 16'h0007, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0002},
              '{16'h0100, 16'h0000, 16'h0001, 16'h0000, 16'h1234, 16'h0000, 16'h7FFE, 16'h0000},
              '{16'h0000, 16'h0010, 16'h0020, 16'h0000, 16'h0030, 16'h7FFF, 16'h0000, 16'h0005},
              '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0008}};
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {gnt, s_ready, busy, relu_valid, m_valid, m_last}, 0);
    chk("rst_data", {relu_x, m_data}, 0);
    chk("rst_tag", {m_id, m_idx}, 0);
    rst = 1'b0;
    req = 2'b01;
    serve(0, 0, 1'b0, 8, 8, w);
    chk("grant_latency", w, 1);
    req = 2'b00;
    wait_idle();
    req = 2'b01;
    serve(0, 1, 1'b1, 8, 8, w);
    req = 2'b00;
    wait_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    serve(0, 2, 1'b0, 8, 8, w);
    chk("grant_latency_both", w, 1);
    serve(1, 3, 1'b0, 8, 8, w);
    serve(0, 1, 1'b0, 8, 8, w);
    serve(1, 0, 1'b1, 8, 8, w);
    req = 2'b00;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("no_regrant", gnt, 0);
    req = 2'b01;
    serve(0, 0, 1'b0, 3, 1, w);
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    chk("midrst_ctrl", {gnt, s_ready, busy, relu_valid, m_valid, m_last}, 0);
    chk("midrst_data", {relu_x, m_data}, 0);
    chk("midrst_tag", {m_id, m_idx}, 0);
    rst = 1'b0;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("stale_ready_1", {m_valid, busy}, 0);
    @(negedge clk);
    chk("stale_ready_2", {m_valid, busy}, 0);
    req = 2'b10;
    serve(1, 3, 1'b0, 8, 8, w);
    chk("grant_latency_r1", w, 1);
    req = 2'b00;
    wait_idle();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
